mips_mem_arbiter: RTL and testbench

//  Arbitrates the single 1024x32 unified memory between three requesters: instruction fetch (IF),

---
 rtl/mips_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Unified-memory arbiter for IF / DM / loader over a 1-cycle-latency single-port SRAM.
// Optional grant statistics outputs when ARB_STATS_EN is defined.
module mips_mem_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic [2:0]    rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
`ifdef ARB_STATS_EN
  output logic [15:0]   stat_if,
  output logic [15:0]   stat_dm,
  output logic [15:0]   stat_ld,
`endif
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned WW = 4;
  localparam int unsigned SW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      owner_q, owner_d;     // one-hot {ld,dm,if}
  logic [2:0]      gnt_q, gnt_d;
  logic [2:0]      rd_valid_q, rd_valid_d;
  logic            ram_en_q, ram_en_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic [WW-1:0]   if_wait_q, if_wait_d;
  logic            force_if;
  logic            arb_en;
  logic [2:0]      win;

`ifdef ARB_STATS_EN
  logic [SW-1:0]   stat_q [3];
  logic [SW-1:0]   stat_d [3];
`endif

  // Next-state, winner selection and registered-output computation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    gnt_d       = 3'b000;
    rd_valid_d  = 3'b000;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_wait_d   = if_wait_q;

    // Fixed LD > DM > IF, except a starved IF overtakes DM
    force_if = (if_wait_q == WW'(MAX_WAIT));
    win[2]   = ld_req;
    win[1]   = dm_req & ~ld_req & ~(if_req & force_if);
    win[0]   = if_req & ~ld_req & (~dm_req | force_if);
    arb_en   = (state_q != ISSUE) && (if_req || dm_req || ld_req);

    if (state_q == ISSUE) begin
      state_d    = RESP;
      rd_valid_d = owner_q & {3{~ram_we_q}};
    end else if (arb_en) begin
      state_d  = ISSUE;
      owner_d  = win;
      gnt_d    = win;
      ram_en_d = 1'b1;
      if (win[2]) begin
        ram_we_d    = ld_we;
        ram_addr_d  = ld_addr;
        ram_wdata_d = ld_wdata;
      end else if (win[1]) begin
        ram_we_d    = dm_we;
        ram_addr_d  = dm_addr;
        ram_wdata_d = dm_wdata;
      end else begin
        ram_we_d    = 1'b0;
        ram_addr_d  = if_addr;
      end
    end else begin
      state_d = IDLE;
    end

    if (!if_req) begin
      if_wait_d = '0;
    end else if (arb_en) begin
      if (win[0])        if_wait_d = '0;
      else if (!force_if) if_wait_d = if_wait_q + WW'(1);
    end

`ifdef ARB_STATS_EN
    for (int i = 0; i < 3; i++) begin
      stat_d[i] = stat_q[i];
      if (gnt_d[i] && (stat_q[i] != {SW{1'b1}})) stat_d[i] = stat_q[i] + SW'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 3'b000;
      gnt_q       <= 3'b000;
      rd_valid_q  <= 3'b000;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_wait_q   <= '0;
`ifdef ARB_STATS_EN
      for (int i = 0; i < 3; i++) stat_q[i] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_wait_q   <= if_wait_d;
`ifdef ARB_STATS_EN
      for (int i = 0; i < 3; i++) stat_q[i] <= stat_d[i];
`endif
    end
  end

  assign if_gnt    = gnt_q[0];
  assign dm_gnt    = gnt_q[1];
  assign ld_gnt    = gnt_q[2];
  assign rd_valid  = rd_valid_q;
  assign rd_data   = ram_rdata;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

`ifdef ARB_STATS_EN
  assign stat_if = stat_q[0];
  assign stat_dm = stat_q[1];
  assign stat_ld = stat_q[2];
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter with a behavioural 1024x32 SRAM.
module tb_mips_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, ld_req;
  logic          dm_we, ld_we;
  logic [AW-1:0] if_addr, dm_addr, ld_addr;
  logic [DW-1:0] dm_wdata, ld_wdata;
  logic          if_gnt, dm_gnt, ld_gnt;
  logic [2:0]    rd_valid;
  logic [DW-1:0] rd_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef ARB_STATS_EN
  logic [15:0]   stat_if, stat_dm, stat_ld;
`endif

  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  logic [DW-1:0] mem [1024];

  int vectors = 0;
  int miscompares = 0;

  wire [2:0] gnt_v = {ld_gnt, dm_gnt, if_gnt};

  always #5 clk = ~clk;

  // SRAM model with a backdoor preload port
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  mips_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef ARB_STATS_EN
    .stat_if(stat_if), .stat_dm(stat_dm), .stat_ld(stat_ld),
`endif
    .ram_rdata(ram_rdata)
  );

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({gnt_v, rd_valid, ram_en, ram_we} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl got gnt=%b rv=%b en=%b we=%b want all 0", gnt_v, rd_valid, ram_en, ram_we);
    end
    vectors++;
    if ({ram_addr, ram_wdata} !== 42'd0) begin
      miscompares++;
      $display("FAIL reset_ram got addr=%h wdata=%h want 0", ram_addr, ram_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_if_read();
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'd5;
    @(negedge clk);
    vectors++;
    if ({gnt_v, ram_en, ram_we, ram_addr} !== {3'b001, 1'b1, 1'b0, 10'd5}) begin
      miscompares++;
      $display("FAIL if_issue got gnt=%b en=%b we=%b addr=%h want 001 1 0 005", gnt_v, ram_en, ram_we, ram_addr);
    end
    if_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (rd_valid !== 3'b001 || rd_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL if_resp got rv=%b data=%h want 001 deadbeef", rd_valid, rd_data);
    end
    @(negedge clk);
    vectors++;
    if ({gnt_v, rd_valid, ram_en} !== 7'd0) begin
      miscompares++;
      $display("FAIL if_idle got gnt=%b rv=%b en=%b want 0", gnt_v, rd_valid, ram_en);
    end
  endtask

  task automatic test_priority();
    logic [2:0]    exp_g [3];
    logic [DW-1:0] exp_d [3];
    exp_g[0] = 3'b100; exp_d[0] = 32'hC3C3_0030;
    exp_g[1] = 3'b010; exp_d[1] = 32'hB2B2_0020;
    exp_g[2] = 3'b001; exp_d[2] = 32'hA1A1_0010;
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'h010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h020;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'h030;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (gnt_v !== exp_g[k]) begin
        miscompares++;
        $display("FAIL prio_gnt%0d got %b want %b", k, gnt_v, exp_g[k]);
      end
      if (k == 0) ld_req = 1'b0;
      if (k == 1) dm_req = 1'b0;
      if (k == 2) if_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (rd_valid !== exp_g[k] || rd_data !== exp_d[k]) begin
        miscompares++;
        $display("FAIL prio_rv%0d got rv=%b data=%h want %b %h", k, rd_valid, rd_data, exp_g[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'h050;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h040;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (gnt_v !== ((k < 4) ? 3'b010 : 3'b001)) begin
        miscompares++;
        $display("FAIL starve_gnt%0d got %b want %b", k, gnt_v, (k < 4) ? 3'b010 : 3'b001);
      end
      if (k == 3) begin
        vectors++;
        if (dut.if_wait_q !== 4'd4) begin
          miscompares++;
          $display("FAIL starve_wait_sat got %0d want 4", dut.if_wait_q);
        end
      end
      if (k == 4) begin
        vectors++;
        if (dut.if_wait_q !== 4'd0) begin
          miscompares++;
          $display("FAIL starve_wait_clr got %0d want 0", dut.if_wait_q);
        end
        if_req = 1'b0; dm_req = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (rd_valid !== ((k < 4) ? 3'b010 : 3'b001) || rd_data !== ((k < 4) ? 32'hD4D4_0040 : 32'hE5E5_0050)) begin
        miscompares++;
        $display("FAIL starve_rv%0d got rv=%b data=%h", k, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'h12345678;
    @(negedge clk);
    vectors++;
    if ({gnt_v, ram_en, ram_we, ram_addr, ram_wdata} !== {3'b010, 1'b1, 1'b1, 10'h3FF, 32'h12345678}) begin
      miscompares++;
      $display("FAIL st_issue got gnt=%b en=%b we=%b addr=%h wd=%h", gnt_v, ram_en, ram_we, ram_addr, ram_wdata);
    end
    dm_we = 1'b0;
    @(negedge clk);
    vectors++;
    if (rd_valid !== 3'b000 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL st_resp got rv=%b we=%b want 000 0", rd_valid, ram_we);
    end
    @(negedge clk);
    vectors++;
    if (gnt_v !== 3'b010 || ram_we !== 1'b0 || ram_addr !== 10'h3FF) begin
      miscompares++;
      $display("FAIL ld_issue got gnt=%b we=%b addr=%h want 010 0 3ff", gnt_v, ram_we, ram_addr);
    end
    dm_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (rd_valid !== 3'b010 || rd_data !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ld_resp got rv=%b data=%h want 010 12345678", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'd7;
    @(negedge clk);
    vectors++;
    if (if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_gnt got %b want 1", if_gnt);
    end
    if_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt_v, ram_en, rd_valid} !== 7'd0) begin
      miscompares++;
      $display("FAIL rst_drop got gnt=%b en=%b rv=%b want 0", gnt_v, ram_en, rd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rd_valid, ram_en} !== 4'd0 || dut.if_wait_q !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_after got rv=%b en=%b wait=%0d want 0", rd_valid, ram_en, dut.if_wait_q);
    end
    if_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (gnt_v !== 3'b001 || ram_addr !== 10'd7) begin
      miscompares++;
      $display("FAIL rst_resend_gnt got gnt=%b addr=%h want 001 007", gnt_v, ram_addr);
    end
    if_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (rd_valid !== 3'b001 || rd_data !== 32'h0000_0077) begin
      miscompares++;
      $display("FAIL rst_resend_rv got rv=%b data=%h want 001 00000077", rd_valid, rd_data);
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic do_access(input int who);
    bit seen = 0;
    @(negedge clk);
    if (who == 0) begin if_req = 1'b1; if_addr = 10'd5; end
    if (who == 1) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd5; end
    if (who == 2) begin ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd5; end
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (gnt_v[who]) seen = 1;
    end
    if_req = 1'b0; dm_req = 1'b0; ld_req = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL stat_gnt_timeout who=%0d got no gnt want gnt", who);
    end
    @(negedge clk);
  endtask

  task automatic test_stats();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(0); do_access(1); do_access(0);
    do_access(2); do_access(1); do_access(0);
    @(negedge clk);
    vectors++;
    if (stat_if !== 16'd3 || stat_dm !== 16'd2 || stat_ld !== 16'd1) begin
      miscompares++;
      $display("FAIL stats got if=%0d dm=%0d ld=%0d want 3 2 1", stat_if, stat_dm, stat_ld);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    if_req = 0; dm_req = 0; ld_req = 0; dm_we = 0; ld_we = 0;
    if_addr = '0; dm_addr = '0; ld_addr = '0; dm_wdata = '0; ld_wdata = '0;
    bd_we = 0; bd_addr = '0; bd_data = '0;
    preload(10'd5,   32'hDEADBEEF);
    preload(10'h010, 32'hA1A1_0010);
    preload(10'h020, 32'hB2B2_0020);
    preload(10'h030, 32'hC3C3_0030);
    preload(10'h040, 32'hD4D4_0040);
    preload(10'h050, 32'hE5E5_0050);
    preload(10'd7,   32'h0000_0077);
    test_reset();
    test_single_if_read();
    test_priority();
    test_starvation();
    test_store_load();
    test_reset_mid_access();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
